// File: rtl/game_pkg.sv
// Shared state encoding and court constants for the rally sequencer.
package game_pkg;

    typedef enum logic [5:0] {
        IDLE        = 6'b000001,
        SETUP       = 6'b000010,
        HOLD        = 6'b000100,
        PLAY        = 6'b001000,
        POINT_PAUSE = 6'b010000,
        GAME_OVER   = 6'b100000
    } state_t;

    localparam int SERVE_X1 = 250;
    localparam int SERVE_X2 = 773;
    localparam int SERVE_Y  = 200;
    localparam int SCORE_W  = 4;

endpackage

// File: rtl/rally_sequencer_tick_gen.sv
// Free-running timebase: tick is high for one clock every SRC_FREQ/TICK_FREQ clocks.
module tick_gen #(
    parameter int SRC_FREQ  = 65_000_000,
    parameter int TICK_FREQ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int DIV = SRC_FREQ / TICK_FREQ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] cnt;

    assign tick = (cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + DW'(1);
    end
endmodule

// File: rtl/rally_sequencer.sv
// Rally game-flow FSM: start, serve setup, countdown, live play, point pause, game over.
// Optional pause button is enabled with `define RALLY_PAUSE_EN.
module rally_sequencer #(
    parameter int SRC_FREQ     = 65_000_000,
    parameter int TICK_FREQ    = 100,
    parameter int HOLD_SECONDS = 3,
    parameter int PAUSE_TICKS  = 150,
    parameter int SERVE_X1     = game_pkg::SERVE_X1,
    parameter int SERVE_X2     = game_pkg::SERVE_X2,
    parameter int SERVE_Y      = game_pkg::SERVE_Y
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_btn,
`ifdef RALLY_PAUSE_EN
    input  logic                         pause_btn,
`endif
    input  logic [game_pkg::SCORE_W-1:0] score_player1,
    input  logic [game_pkg::SCORE_W-1:0] score_player2,
    input  logic                         endgame,
    output logic                         freeze,
    output logic                         ball_reset,
    output logic [11:0]                  ball_x,
    output logic [11:0]                  ball_y,
    output logic                         serve_side,
    output logic [3:0]                   countdown,
    output logic                         game_restart
);
    import game_pkg::*;

    localparam int TCNT_MAX = (TICK_FREQ > PAUSE_TICKS) ? TICK_FREQ : PAUSE_TICKS;
    localparam int TW       = $clog2(TCNT_MAX + 1);
    localparam logic [TW-1:0] SEC_LAST   = TW'(TICK_FREQ - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);

    state_t             state;
    logic               tick;
    logic               start_q, start_pulse;
    logic [TW-1:0]      tcnt;
    logic [SCORE_W-1:0] prev_p1, prev_p2;
    logic               p1_pt, p2_pt, run;
    logic               paused, paused_nxt;

    tick_gen #(.SRC_FREQ(SRC_FREQ), .TICK_FREQ(TICK_FREQ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == SETUP),
        .tick (tick)
    );

`ifdef RALLY_PAUSE_EN
    logic pause_q, pause_edge;
    assign pause_edge = pause_btn & ~pause_q;
    assign paused_nxt = (state == SETUP) ? 1'b0
                      : paused ^ (pause_edge & ((state == HOLD) || (state == PLAY)));

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= pause_btn;
            paused  <= 1'b0;
        end else begin
            pause_q <= pause_btn;
            paused  <= paused_nxt;
        end
    end
`else
    assign paused     = 1'b0;
    assign paused_nxt = 1'b0;
`endif

    assign run   = ~paused;
    assign p1_pt = run && (score_player1 != prev_p1);
    assign p2_pt = run && (score_player2 != prev_p2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            freeze       <= 1'b1;
            ball_reset   <= 1'b0;
            ball_x       <= 12'(SERVE_X1);
            ball_y       <= 12'(SERVE_Y);
            serve_side   <= 1'b0;
            countdown    <= 4'd0;
            game_restart <= 1'b0;
            tcnt         <= '0;
            prev_p1      <= '0;
            prev_p2      <= '0;
            // Load the live button level so a button held through reset is not an edge.
            start_q      <= start_btn;
            start_pulse  <= 1'b0;
        end else begin
            prev_p1      <= score_player1;
            prev_p2      <= score_player2;
            start_q      <= start_btn;
            start_pulse  <= start_btn & ~start_q;
            ball_reset   <= 1'b0;
            game_restart <= 1'b0;

            case (state)
                IDLE: begin
                    freeze <= 1'b1;
                    if (start_pulse) begin
                        state      <= SETUP;
                        serve_side <= 1'b0;
                        ball_reset <= 1'b1;
                        ball_x     <= 12'(SERVE_X1);
                        ball_y     <= 12'(SERVE_Y);
                        countdown  <= 4'(HOLD_SECONDS);
                        tcnt       <= '0;
                    end
                end
                SETUP: begin
                    freeze <= 1'b1;
                    state  <= HOLD;
                end
                HOLD: begin
                    freeze <= 1'b1;
                    if (run && tick) begin
                        if (tcnt == SEC_LAST) begin
                            tcnt      <= '0;
                            countdown <= countdown - 4'd1;
                            if (countdown == 4'd1) begin
                                state  <= PLAY;
                                freeze <= paused_nxt;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                PLAY: begin
                    freeze <= paused_nxt;
                    if (p1_pt || p2_pt) begin
                        state  <= POINT_PAUSE;
                        freeze <= 1'b1;
                        tcnt   <= '0;
                        // A simultaneous double change keeps the current server.
                        if (!(p1_pt && p2_pt))
                            serve_side <= p2_pt;
                    end
                end
                POINT_PAUSE: begin
                    freeze <= 1'b1;
                    if (tick) begin
                        if (tcnt == PAUSE_LAST) begin
                            tcnt <= '0;
                            if (endgame) begin
                                state <= GAME_OVER;
                            end else begin
                                state      <= SETUP;
                                ball_reset <= 1'b1;
                                ball_x     <= serve_side ? 12'(SERVE_X2) : 12'(SERVE_X1);
                                ball_y     <= 12'(SERVE_Y);
                                countdown  <= 4'(HOLD_SECONDS);
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    freeze <= 1'b1;
                    if (start_pulse) begin
                        state        <= IDLE;
                        game_restart <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    freeze <= 1'b1;
                end
            endcase
        end
    end
endmodule
